vga_timing: RTL and testbench



---
 rtl/vga_timing.sv | 104 ++++++++++
 tb/tb_vga_timing.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// 1024x768@60 pixel timing generator: registered counters, syncs, blanking and frame pulse.
// Latency: flags are registered together with the counters they describe; free-running, no backpressure.
// Optional frame counter enabled by defining VGA_FRAME_CNT_EN; otherwise frame_cnt is tied to 0.
package vga_pkg;
  localparam logic [10:0] HOR_PIXELS   = 11'd1024;
  localparam logic [10:0] HBLANK_START = 11'd1024;
  localparam logic [10:0] HBLANK_STOP  = 11'd1344;
  localparam logic [10:0] HSYNC_START  = 11'd1048;
  localparam logic [10:0] HSYNC_STOP   = 11'd1184;
  localparam logic [10:0] VER_PIXELS   = 11'd768;
  localparam logic [10:0] VBLANK_START = 11'd768;
  localparam logic [10:0] VBLANK_STOP  = 11'd806;
  localparam logic [10:0] VSYNC_START  = 11'd771;
  localparam logic [10:0] VSYNC_STOP   = 11'd777;
endpackage

module vga_timing
  import vga_pkg::*;
#(
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [10:0]            hcount,
  output logic [10:0]            vcount,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   hblnk,
  output logic                   vblnk,
  output logic                   frame_start,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam logic [10:0] H_LAST = HBLANK_STOP - 11'd1;
  localparam logic [10:0] V_LAST = VBLANK_STOP - 11'd1;

  // run holds the counters at (0,0) for the first edge after reset release
  logic        run;
  logic [10:0] h_nxt;
  logic [10:0] v_nxt;
  logic        wrap;

  always_comb begin
    h_nxt = 11'd0;
    v_nxt = 11'd0;
    wrap  = 1'b0;
    if (run) begin
      v_nxt = vcount;
      if (hcount >= HBLANK_STOP) begin
        h_nxt = 11'd0;
      end else if (hcount == H_LAST) begin
        h_nxt = 11'd0;
        if (vcount == V_LAST) begin
          v_nxt = 11'd0;
          wrap  = 1'b1;
        end else begin
          v_nxt = vcount + 11'd1;
        end
      end else begin
        h_nxt = hcount + 11'd1;
      end
      // out-of-range vertical state recovers to line 0 without a frame pulse
      if (vcount >= VBLANK_STOP) begin
        v_nxt = 11'd0;
        wrap  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run         <= 1'b0;
      hcount      <= 11'd0;
      vcount      <= 11'd0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      run         <= 1'b1;
      hcount      <= h_nxt;
      vcount      <= v_nxt;
      hsync       <= (h_nxt >= HSYNC_START) && (h_nxt < HSYNC_STOP);
      vsync       <= (v_nxt >= VSYNC_START) && (v_nxt < VSYNC_STOP);
      hblnk       <= (h_nxt >= HBLANK_START);
      vblnk       <= (v_nxt >= VBLANK_START);
      frame_start <= wrap;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (wrap) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing; uses state deposits to reach vertical boundaries quickly.
module tb_vga_timing;
  localparam int FCW = 4;
`ifdef VGA_FRAME_CNT_EN
  localparam bit FCE = 1'b1;
`else
  localparam bit FCE = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [10:0]    hcount;
  logic [10:0]    vcount;
  logic           hsync;
  logic           vsync;
  logic           hblnk;
  logic           vblnk;
  logic           frame_start;
  logic [FCW-1:0] frame_cnt;

  vga_timing #(.FRAME_CNT_W(FCW)) dut (
    .clk         (clk),
    .rst         (rst),
    .hcount      (hcount),
    .vcount      (vcount),
    .hsync       (hsync),
    .vsync       (vsync),
    .hblnk       (hblnk),
    .vblnk       (vblnk),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int exh    = 0;
  int exv    = 0;
  int exfc   = 0;
  bit exfs   = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic check_state();
    chk("hcount", int'(hcount), exh);
    chk("vcount", int'(vcount), exv);
    chk("hsync", int'(hsync), int'(exh >= 1048 && exh <= 1183));
    chk("hblnk", int'(hblnk), int'(exh >= 1024));
    chk("vsync", int'(vsync), int'(exv >= 771 && exv <= 776));
    chk("vblnk", int'(vblnk), int'(exv >= 768));
    chk("frame_start", int'(frame_start), int'(exfs));
    chk("frame_cnt", int'(frame_cnt), FCE ? exfc : 0);
    chk("hsync_in_hblnk", int'(hsync & ~hblnk), 0);
    chk("vsync_in_vblnk", int'(vsync & ~vblnk), 0);
  endtask

  task automatic tick();
    @(negedge clk);
    exfs = 1'b0;
    if (exh == 1343) begin
      exh = 0;
      if (exv == 805) begin
        exv  = 0;
        exfs = 1'b1;
        exfc = (exfc + 1) % (1 << FCW);
      end else begin
        exv = exv + 1;
      end
    end else begin
      exh = exh + 1;
    end
    check_state();
  endtask

  // called at a falling edge: the next rising edge steps from the deposited position
  task automatic jump(input int h, input int v);
    dut.hcount = 11'(h);
    dut.vcount = 11'(v);
    exh = h;
    exv = v;
  endtask

  initial begin
    int hs_n;
    int hb_first;
    int vs_n;
    int fs_n;

    repeat (2) @(negedge clk);
    check_state();

    rst = 1'b0;
    @(negedge clk);
    chk("hold_first_edge", int'(hcount), 0);
    check_state();

    hs_n = 0;
    hb_first = -1;
    for (int i = 0; i < 1344; i++) begin
      tick();
      if (hsync) hs_n++;
      if (hblnk && hb_first < 0) hb_first = int'(hcount);
    end
    chk("hsync_cycles", hs_n, 136);
    chk("hblnk_first", hb_first, 1024);
    chk("line_wrap_v", int'(vcount), 1);

    jump(1340, 767);
    repeat (4) tick();
    chk("vblnk_rise", int'(vblnk), 1);
    repeat (4) tick();

    jump(1330, 770);
    vs_n = 0;
    for (int i = 0; i < 8100; i++) begin
      tick();
      if (vsync) vs_n++;
    end
    chk("vsync_cycles", vs_n, 8064);

    jump(1340, 805);
    fs_n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (frame_start) begin
        fs_n++;
        chk("frame_start_pos", int'(hcount) + int'(vcount), 0);
      end
    end
    chk("frame_start_once", fs_n, 1);

    for (int f = 0; f < 15; f++) begin
      jump(1342, 805);
      repeat (4) tick();
      if (f == 1) chk("frames3", int'(frame_cnt), FCE ? 3 : 0);
    end
    chk("frames16", int'(frame_cnt), 0);

    dut.hcount = 11'd2000;
    dut.vcount = 11'd900;
    @(negedge clk);
    chk("seu_h", int'(hcount), 0);
    chk("seu_v", int'(vcount), 0);
    chk("seu_no_fs", int'(frame_start), 0);
    exh = 0;
    exv = 0;
    exfs = 1'b0;
    repeat (3) tick();

    jump(495, 400);
    repeat (5) tick();
    chk("pre_rst_h", int'(hcount), 500);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    exh = 0;
    exv = 0;
    exfs = 1'b0;
    exfc = 0;
    check_state();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_hold_edge1", int'(hcount), 0);
    check_state();
    tick();
    chk("rst_edge2_h", int'(hcount), 1);
    chk("rst_no_fs", int'(frame_start), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
